led_pwm_ctrl: RTL and testbench
===============================

LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 100, aclk cycles per PWM tick (minimum 2).
REQ-002 SHALL have parameter CNT_W, default 16, width of the period and duty fields.
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic is rising-edge on aclk.
REQ-004 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cfg_valid, input, 1, new configuration offered by the upstream AXI-Lite register block.
REQ-006 SHALL have port cfg_ready, output, 1, configuration accepted when high together with cfg_valid.
REQ-007 SHALL have port cfg_enable, input, 1, run (1) or stop (0).
REQ-008 SHALL have port cfg_period, input, CNT_W, last tick index of the PWM period (period length = cfg_period+1 ticks).
REQ-009 SHALL have port cfg_duty_r, input, CNT_W, red on-ticks per period.
REQ-010 SHALL have port cfg_duty_g, input, CNT_W, green on-ticks per period.
REQ-011 SHALL have port cfg_blink, input, 8, blink half-cycle in periods; 0 = no blink.
REQ-012 SHALL have port led_r_o, output, 1, red LED drive (pl_led_r).
REQ-013 SHALL have port led_g_o, output, 1, green LED drive (pl_led_g).
REQ-014 SHALL have port period_done, output, 1, one-cycle pulse at each period wrap while running.

Function
REQ-015 SHALL generate a tick every PRESCALE aclk cycles from a prescaler that counts 0..PRESCALE-1 only in RUN.
REQ-016 SHALL advance the period counter on each tick, 0..active period, wrapping to 0 with period_done high for exactly that aclk cycle.
REQ-017 SHALL drive each LED high when count < active duty and the blink phase is ON, registered (one aclk of latency from count to pin).
REQ-018 SHALL hold an LED constantly low for duty 0 and constantly high for duty > period; period 0 gives a 1-tick period.
REQ-019 SHALL accept a configuration when cfg_valid && cfg_ready, capturing all cfg_* fields into a pending shadow set and dropping cfg_ready until it is applied.
REQ-020 SHALL apply the pending set immediately in IDLE, and in RUN only on the aclk cycle of a period wrap; a glitched partial period SHALL never occur.
REQ-021 SHALL use states IDLE (outputs low, counters zero), RUN and, when cfg_blink != 0, toggle the blink phase (ON/OFF) every cfg_blink completed periods, starting ON.
REQ-022 SHALL transition IDLE->RUN when an applied set has enable=1, RUN->IDLE when an applied set has enable=0, clearing all counters and forcing LEDs low the next cycle.
REQ-023 SHALL, when cfg_valid arrives on the same cycle as a wrap with no pending set, capture it and apply it at the next wrap (not the current one).
REQ-024 SHALL raise cfg_ready the cycle after the pending set is applied.

Reset
REQ-025 SHALL, on aresetn low, immediately force led_r_o=0, led_g_o=0, period_done=0, cfg_ready=1, state IDLE, all counters, shadow and active registers to 0, blink phase ON.
REQ-026 SHALL discard any pending set when reset asserts mid-operation and resume only on a new handshake after release.

Configuration
REQ-027 SHALL, with macro LED_PWM_BREATH_EN defined, add input cfg_breath (1 bit, captured with the set) which ramps the effective duty by 1 each period from 0 up to the configured duty and back to 0, repeating.
REQ-028 SHALL, without LED_PWM_BREATH_EN, omit the cfg_breath port and ramp logic, using the configured duty directly.

Structure
REQ-029 SHALL place the state enum (IDLE, RUN), blink phase enum and the default CNT_W/PRESCALE constants in shared package led_pwm_pkg.
REQ-030 SHALL instantiate per colour one sub-module led_pwm_chan (duty compare, breath ramp, blink gating, output register).

Verification
REQ-031 SHALL verify PRESCALE=4, period=9, duty_r=3, duty_g=0, enable=1 -> led_r high 12 aclk of every 40, led_g always 0, period_done every 40 aclk.
REQ-032 SHALL verify a new set with duty_r=7 offered mid-period -> cfg_ready low until wrap, old duty until wrap, 7-tick high from the next period.
REQ-033 SHALL verify duty_g=15 with period=9 -> led_g constantly high; period=0, duty=1 -> constantly high.
REQ-034 SHALL verify cfg_blink=2 -> LEDs active 2 periods, low 2 periods, repeating, phase starting ON.
REQ-035 SHALL verify aresetn pulsed low mid-period with a pending set -> outputs 0 immediately, cfg_ready=1 after release, no stale set applied.
REQ-036 SHALL verify, with LED_PWM_BREATH_EN and cfg_breath=1, duty=3 -> effective duty sequence 0,1,2,3,2,1,0 over consecutive periods.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared types and default constants for the two-colour LED PWM controller.
// The optional breathing ramp is enabled by defining LED_PWM_BREATH_EN.
package led_pwm_pkg;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_PRESCALE = 100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } phase_t;

endpackage

// File: rtl/led_pwm_chan.sv
// One PWM colour channel: optional breath ramp, duty compare, blink gating, output register.
// The breath ramp exists only when LED_PWM_BREATH_EN is defined.
module led_pwm_chan
    import led_pwm_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
)
(
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic             wrap,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] duty,
`ifdef LED_PWM_BREATH_EN
    input  logic             breath,
`endif
    input  phase_t           phase,
    output logic             led
);

    logic [CNT_W-1:0] eff_duty;

`ifdef LED_PWM_BREATH_EN
    logic [CNT_W-1:0] ramp;
    logic             ramp_up;

    // Triangle ramp 0..duty..0, one step per completed period.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ramp    <= '0;
            ramp_up <= 1'b1;
        end else if (clear) begin
            ramp    <= '0;
            ramp_up <= 1'b1;
        end else if (wrap) begin
            if (ramp_up) begin
                if (ramp < duty) begin
                    ramp <= ramp + CNT_W'(1);
                    if (ramp + CNT_W'(1) == duty) ramp_up <= 1'b0;
                end else begin
                    ramp_up <= 1'b0;
                end
            end else begin
                if (ramp != '0) begin
                    ramp <= ramp - CNT_W'(1);
                    if (ramp == CNT_W'(1)) ramp_up <= 1'b1;
                end else begin
                    ramp_up <= 1'b1;
                end
            end
        end
    end

    // Clamp so a duty lowered mid-ramp takes effect at once.
    always_comb begin
        eff_duty = duty;
        if (breath) eff_duty = (ramp < duty) ? ramp : duty;
    end
`else
    assign eff_duty = duty;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)   led <= 1'b0;
        else if (clear) led <= 1'b0;
        else            led <= (cnt < eff_duty) && (phase == PH_ON);
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Two-colour LED PWM controller with shadowed configuration applied only at period wraps.
// Define LED_PWM_BREATH_EN to add the cfg_breath input and per-channel breathing ramp.
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int CNT_W    = DEF_CNT_W
)
(
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_enable,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty_r,
    input  logic [CNT_W-1:0] cfg_duty_g,
    input  logic [7:0]       cfg_blink,
`ifdef LED_PWM_BREATH_EN
    input  logic             cfg_breath,
`endif
    output logic             led_r_o,
    output logic             led_g_o,
    output logic             period_done,
    output state_t           dbg_state
);

    localparam int PW = $clog2(PRESCALE);

    state_t           state, next_state;
    logic             running, chan_clear, apply, tick, wrap;
    logic [PW-1:0]    presc;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       blink_cnt;
    phase_t           phase;

    logic             pend_valid, pend_enable;
    logic [CNT_W-1:0] pend_period, pend_duty_r, pend_duty_g;
    logic [7:0]       pend_blink;
    logic [CNT_W-1:0] act_period, act_duty_r, act_duty_g;
    logic [7:0]       act_blink;
`ifdef LED_PWM_BREATH_EN
    logic             pend_breath, act_breath;
`endif

    // Handshake: a set transfers on a rising aclk edge where cfg_valid && cfg_ready;
    // cfg_ready stays low while a captured set waits to be applied.
    assign cfg_ready = ~pend_valid;
    assign tick      = (state == ST_RUN) && (presc == PW'(PRESCALE - 1));
    assign wrap      = tick && (cnt == act_period);
    assign apply     = pend_valid && ((state == ST_IDLE) || wrap);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (apply) next_state = pend_enable ? ST_RUN : ST_IDLE;
    end

    // Channels are held clear unless running both now and next cycle.
    always_comb begin
        running    = (state == ST_RUN);
        chan_clear = !(running && (next_state == ST_RUN));
        dbg_state  = state;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pend_valid  <= 1'b0;
            pend_enable <= 1'b0;
            pend_period <= '0;
            pend_duty_r <= '0;
            pend_duty_g <= '0;
            pend_blink  <= '0;
            act_period  <= '0;
            act_duty_r  <= '0;
            act_duty_g  <= '0;
            act_blink   <= '0;
`ifdef LED_PWM_BREATH_EN
            pend_breath <= 1'b0;
            act_breath  <= 1'b0;
`endif
        end else begin
            if (cfg_valid && cfg_ready) begin
                pend_valid  <= 1'b1;
                pend_enable <= cfg_enable;
                pend_period <= cfg_period;
                pend_duty_r <= cfg_duty_r;
                pend_duty_g <= cfg_duty_g;
                pend_blink  <= cfg_blink;
`ifdef LED_PWM_BREATH_EN
                pend_breath <= cfg_breath;
`endif
            end else if (apply) begin
                pend_valid <= 1'b0;
            end
            if (apply) begin
                act_period <= pend_period;
                act_duty_r <= pend_duty_r;
                act_duty_g <= pend_duty_g;
                act_blink  <= pend_blink;
`ifdef LED_PWM_BREATH_EN
                act_breath <= pend_breath;
`endif
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            presc       <= '0;
            cnt         <= '0;
            period_done <= 1'b0;
        end else begin
            period_done <= wrap;
            if (!running) begin
                presc <= '0;
                cnt   <= '0;
            end else if (tick) begin
                presc <= '0;
                cnt   <= wrap ? '0 : cnt + CNT_W'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Blink phase flips after every act_blink completed periods, starting ON.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            blink_cnt <= '0;
            phase     <= PH_ON;
        end else if (chan_clear) begin
            blink_cnt <= '0;
            phase     <= PH_ON;
        end else if (wrap && (act_blink != 8'd0)) begin
            if (blink_cnt == act_blink - 8'd1) begin
                blink_cnt <= '0;
                phase     <= (phase == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    led_pwm_chan #(.CNT_W(CNT_W)) u_chan_r (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (chan_clear),
        .wrap    (wrap),
        .cnt     (cnt),
        .duty    (act_duty_r),
`ifdef LED_PWM_BREATH_EN
        .breath  (act_breath),
`endif
        .phase   (phase),
        .led     (led_r_o)
    );

    led_pwm_chan #(.CNT_W(CNT_W)) u_chan_g (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (chan_clear),
        .wrap    (wrap),
        .cnt     (cnt),
        .duty    (act_duty_g),
`ifdef LED_PWM_BREATH_EN
        .breath  (act_breath),
`endif
        .phase   (phase),
        .led     (led_g_o)
    );

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl: each PWM period is summarised as (length, red-high cycles, green-high cycles)
// and checked against hand-computed values; LED_PWM_BREATH_EN adds the breathing sequence.
module tb_led_pwm_ctrl;
    import led_pwm_pkg::*;

    localparam int PRESCALE = 4;
    localparam int CNT_W    = 16;

    logic             aclk       = 1'b0;
    logic             aresetn    = 1'b0;
    logic             cfg_valid  = 1'b0;
    logic             cfg_enable = 1'b0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_duty_r = '0;
    logic [CNT_W-1:0] cfg_duty_g = '0;
    logic [7:0]       cfg_blink  = '0;
    logic             cfg_breath = 1'b0;
    logic             cfg_ready, led_r_o, led_g_o, period_done;
    state_t           dbg_state;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          clr_req = 0;
    int          clr_ack = 0;
    logic [47:0] exp_q[$];

    always #5 aclk = ~aclk;

    led_pwm_ctrl #(.PRESCALE(PRESCALE), .CNT_W(CNT_W)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_enable  (cfg_enable),
        .cfg_period  (cfg_period),
        .cfg_duty_r  (cfg_duty_r),
        .cfg_duty_g  (cfg_duty_g),
        .cfg_blink   (cfg_blink),
`ifdef LED_PWM_BREATH_EN
        .cfg_breath  (cfg_breath),
`endif
        .led_r_o     (led_r_o),
        .led_g_o     (led_g_o),
        .period_done (period_done),
        .dbg_state   (dbg_state)
    );

    // Monitor: a window runs from the cycle after one period_done up to and including the next.
    int          acc_len = 0;
    int          acc_r = 0;
    int          acc_g = 0;
    logic [47:0] exp_w, got_w;
    always @(negedge aclk) begin
        if (clr_req != clr_ack) begin
            clr_ack = clr_req;
            acc_len = 0;
            acc_r   = 0;
            acc_g   = 0;
        end else begin
            acc_len = acc_len + 1;
            acc_r   = acc_r + int'(led_r_o);
            acc_g   = acc_g + int'(led_g_o);
        end
        if (period_done) begin
            n_cmp = n_cmp + 1;
            got_w = {16'(acc_len), 16'(acc_r), 16'(acc_g)};
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL period_done: unexpected pulse (len=%0d r=%0d g=%0d), none required",
                         acc_len, acc_r, acc_g);
            end else begin
                exp_w = exp_q.pop_front();
                if (got_w !== exp_w) begin
                    n_fail = n_fail + 1;
                    $display("FAIL window: got len=%0d r=%0d g=%0d, required len=%0d r=%0d g=%0d",
                             got_w[47:32], got_w[31:16], got_w[15:0],
                             exp_w[47:32], exp_w[31:16], exp_w[15:0]);
                end
            end
            acc_len = 0;
            acc_r   = 0;
            acc_g   = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp = n_cmp + 1;
        if (got !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push(input int len, input int r, input int g);
        exp_q.push_back({16'(len), 16'(r), 16'(g)});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Offer one set; returns #1 after the accepting edge (or after the apply edge when from_idle).
    task automatic send_cfg(input logic en, input logic [15:0] per, input logic [15:0] dr,
                            input logic [15:0] dg, input logic [7:0] bl, input logic br,
                            input bit from_idle);
        int waited = 0;
        cfg_enable = en;
        cfg_period = per;
        cfg_duty_r = dr;
        cfg_duty_g = dg;
        cfg_blink  = bl;
        cfg_breath = br;
        cfg_valid  = 1'b1;
        while (!cfg_ready && waited < 200) begin
            cycles(1);
            waited++;
        end
        check("cfg_ready wait bound", 32'(waited < 200), 32'd1);
        cycles(1);
        cfg_valid = 1'b0;
        check("cfg_ready low after accept", 32'(cfg_ready), 32'd0);
        if (from_idle) begin
            cycles(1);
            clr_req = clr_req + 1;
            check("state after idle apply", 32'(dbg_state), en ? 32'(ST_RUN) : 32'(ST_IDLE));
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            cycles(1);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(3);
        check("reset led_r", 32'(led_r_o), 32'd0);
        check("reset led_g", 32'(led_g_o), 32'd0);
        check("reset period_done", 32'(period_done), 32'd0);
        check("reset cfg_ready", 32'(cfg_ready), 32'd1);
        check("reset state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge aclk);
        aresetn = 1'b1;
        cycles(1);

        // Basic run: 3 of 10 ticks high at 4 clocks per tick.
        repeat (3) push(40, 12, 0);
        send_cfg(1'b1, 16'd9, 16'd3, 16'd0, 8'd0, 1'b0, 1'b1);
        wait_drain("basic run drain");

        // Mid-period update to duty 7 waits for the wrap.
        push(40, 12, 0);
        repeat (2) push(40, 28, 0);
        cycles(10);
        send_cfg(1'b1, 16'd9, 16'd7, 16'd0, 8'd0, 1'b0, 1'b0);
        cycles(5);
        check("cfg_ready held until wrap", 32'(cfg_ready), 32'd0);
        wait_drain("duty update drain");
        check("cfg_ready after apply", 32'(cfg_ready), 32'd1);

        // Green duty above period is constantly high.
        push(40, 28, 0);
        repeat (2) push(40, 28, 40);
        cycles(10);
        send_cfg(1'b1, 16'd9, 16'd7, 16'd15, 8'd0, 1'b0, 1'b0);
        wait_drain("duty over period drain");

        // Period 0 is a single tick; duty 1 keeps both LEDs high.
        push(40, 28, 40);
        repeat (3) push(4, 4, 4);
        cycles(10);
        send_cfg(1'b1, 16'd0, 16'd1, 16'd1, 8'd0, 1'b0, 1'b0);
        wait_drain("period zero drain");

        // Blink every 2 periods, starting ON.
        push(4, 4, 4);
        repeat (2) push(40, 12, 0);
        repeat (2) push(40, 0, 0);
        repeat (2) push(40, 12, 0);
        cycles(1);
        send_cfg(1'b1, 16'd9, 16'd3, 16'd0, 8'd2, 1'b0, 1'b0);
        wait_drain("blink drain");

        // Disable: the current (blink-OFF) period completes, then IDLE.
        push(40, 0, 0);
        cycles(10);
        send_cfg(1'b0, 16'd9, 16'd3, 16'd0, 8'd2, 1'b0, 1'b0);
        wait_drain("disable drain");
        cycles(50);
        check("idle led_r", 32'(led_r_o), 32'd0);
        check("idle led_g", 32'(led_g_o), 32'd0);
        check("idle state", 32'(dbg_state), 32'(ST_IDLE));

        // Reset mid-period with a pending set.
        send_cfg(1'b1, 16'd9, 16'd3, 16'd0, 8'd0, 1'b0, 1'b1);
        send_cfg(1'b1, 16'd9, 16'd8, 16'd8, 8'd0, 1'b0, 1'b0);
        cycles(4);
        check("led_r high before reset", 32'(led_r_o), 32'd1);
        aresetn = 1'b0;
        #1;
        check("async reset led_r", 32'(led_r_o), 32'd0);
        check("async reset led_g", 32'(led_g_o), 32'd0);
        check("async reset cfg_ready", 32'(cfg_ready), 32'd1);
        check("async reset state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        cycles(100);
        check("post reset led_r", 32'(led_r_o), 32'd0);
        check("post reset led_g", 32'(led_g_o), 32'd0);
        check("post reset state", 32'(dbg_state), 32'(ST_IDLE));
        check("post reset cfg_ready", 32'(cfg_ready), 32'd1);

        repeat (2) push(40, 12, 0);
        send_cfg(1'b1, 16'd9, 16'd3, 16'd0, 8'd0, 1'b0, 1'b1);
        wait_drain("restart drain");

`ifdef LED_PWM_BREATH_EN
        push(40, 12, 0);
        cycles(10);
        send_cfg(1'b0, 16'd9, 16'd3, 16'd0, 8'd0, 1'b0, 1'b0);
        wait_drain("pre-breath disable drain");
        cycles(5);
        // Effective duty 0,1,2,3,2,1,0 -> red-high cycles x4.
        push(40, 0, 0);
        push(40, 4, 0);
        push(40, 8, 0);
        push(40, 12, 0);
        push(40, 8, 0);
        push(40, 4, 0);
        push(40, 0, 0);
        send_cfg(1'b1, 16'd9, 16'd3, 16'd0, 8'd0, 1'b1, 1'b1);
        wait_drain("breath drain");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
